// File: rtl/hazard_pkg.sv
// ----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the pipeline hazard controller:
//   - state_e      : controller states (IDLE, MDU_WAIT, MDU_RELEASE)
//   - REG_ZERO     : address of the hard-wired zero register
//   - wait_cnt_w() : width of the MDU wait counter for a given timeout
// ----------------------------------------------------------------------------
package hazard_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        MDU_WAIT    = 2'd1,
        MDU_RELEASE = 2'd2
    } state_e;

    localparam int REG_ZERO = 0;

    // The wait counter must be able to hold the value MDU_TIMEOUT itself.
    function automatic int wait_cnt_w(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter used for the stall/flush performance counters.
// Ports:
//   clk  in  clock
//   rst  in  synchronous active-high reset (clears the count)
//   inc  in  count enable for this cycle
//   cnt  out current count, sticks at all-ones
// ----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller. Detects load-use hazards and taken branches
// resolved in EX, and sequences the multi-cycle MDU while its instruction is
// held in ID. Control outputs are Mealy (combinational from state + inputs)
// so the pipeline registers react in the same cycle.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   id_rs_addr/id_rt_addr         ID source register addresses
//   id_rs_used/id_rt_used         ID instruction reads rs / rt
//   id_is_mdu                     ID instruction needs the MDU
//   ex_is_load, ex_wr_addr        EX load flag and destination register
//   ex_branch_taken               taken branch/jump resolved in EX
//   mdu_done                      MDU result-ready pulse
//   pc_hold, if_id_hold           front-end hold controls
//   if_id_flush, id_ex_flush      flush controls
//   id_ex_stall                   ID/EX loads a bubble
//   mdu_start                     single-cycle MDU launch pulse
//   mdu_err                       sticky MDU timeout flag
//   stall_cnt, flush_cnt          saturating performance counters
// ----------------------------------------------------------------------------
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int MDU_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs_addr,
    input  logic [REG_ADDR_W-1:0] id_rt_addr,
    input  logic                  id_rs_used,
    input  logic                  id_rt_used,
    input  logic                  id_is_mdu,
    input  logic                  ex_is_load,
    input  logic [REG_ADDR_W-1:0] ex_wr_addr,
    input  logic                  ex_branch_taken,
    input  logic                  mdu_done,
    output logic                  pc_hold,
    output logic                  if_id_hold,
    output logic                  if_id_flush,
    output logic                  id_ex_stall,
    output logic                  id_ex_flush,
    output logic                  mdu_start,
    output logic                  mdu_err,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam int WCW = wait_cnt_w(MDU_TIMEOUT);

    state_e           state_q, state_d;
    logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
    logic             mdu_err_q, mdu_err_d;
    logic             load_use;
    logic             hold;

    assign load_use = ex_is_load
                    && (ex_wr_addr != REG_ADDR_W'(REG_ZERO))
                    && ((id_rs_used && (id_rs_addr == ex_wr_addr))
                     || (id_rt_used && (id_rt_addr == ex_wr_addr)));

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mdu_err_d   = mdu_err_q;
        hold        = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        mdu_start   = 1'b0;

        case (state_q)
            IDLE: begin
                // Branch wins so a wrong-path MDU op is never launched.
                if (ex_branch_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (load_use) begin
                    hold = 1'b1;
                end else if (id_is_mdu) begin
                    hold       = 1'b1;
                    mdu_start  = 1'b1;
                    state_d    = MDU_WAIT;
                    wait_cnt_d = WCW'(1);
                end
            end
            MDU_WAIT: begin
                // EX only holds bubbles here, so branches cannot occur.
                hold = 1'b1;
                if (mdu_done) begin
                    state_d = MDU_RELEASE;
                end else if (wait_cnt_q == WCW'(MDU_TIMEOUT)) begin
                    mdu_err_d = 1'b1;
                    state_d   = MDU_RELEASE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end
            end
            MDU_RELEASE: begin
                // One clean cycle lets the MDU instruction advance to EX.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rst) begin
            hold        = 1'b0;
            if_id_flush = 1'b0;
            id_ex_flush = 1'b0;
            mdu_start   = 1'b0;
        end
    end

    assign pc_hold     = hold;
    assign if_id_hold  = hold;
    assign id_ex_stall = hold;
    assign mdu_err     = mdu_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            mdu_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mdu_err_q  <= mdu_err_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (hold),
        .cnt (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (if_id_flush),
        .cnt (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_hazard_ctrl
// Two controllers share one stimulus stream: u0 with default parameters and
// u1 with MDU_TIMEOUT=4, CNT_W=3 (for timeout and saturation behaviour).
// Control outputs are packed as
//   {pc_hold, if_id_hold, if_id_flush, id_ex_stall, id_ex_flush, mdu_start}
// ----------------------------------------------------------------------------
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs_a, rt_a, wr_a;
    logic       rs_u, rt_u, is_mdu, is_ld, br, done;

    logic       ph0, ih0, ff0, st0, ef0, ms0, err0;
    logic       ph1, ih1, ff1, st1, ef1, ms1, err1;
    logic [31:0] sc0, fc0;
    logic [2:0]  sc1, fc1;
    logic [5:0]  ctl0, ctl1, last0, last1;

    int checks = 0;
    int errors = 0;

    // Reference model state (per instance).
    int     m_mode [2];   // 0 idle, 1 waiting on MDU, 2 release cycle
    int     m_el   [2];   // wait cycles spent so far
    bit     m_err  [2];
    longint m_st   [2];
    longint m_fl   [2];
    longint cmax   [2];
    int     tmo    [2];

    localparam logic [5:0] HOLD  = 6'b110100;
    localparam logic [5:0] START = 6'b110101;
    localparam logic [5:0] FLSH  = 6'b001010;

    always #5 clk = ~clk;

    hazard_ctrl u0 (
        .clk(clk), .rst(rst),
        .id_rs_addr(rs_a), .id_rt_addr(rt_a), .id_rs_used(rs_u), .id_rt_used(rt_u),
        .id_is_mdu(is_mdu), .ex_is_load(is_ld), .ex_wr_addr(wr_a),
        .ex_branch_taken(br), .mdu_done(done),
        .pc_hold(ph0), .if_id_hold(ih0), .if_id_flush(ff0), .id_ex_stall(st0),
        .id_ex_flush(ef0), .mdu_start(ms0), .mdu_err(err0),
        .stall_cnt(sc0), .flush_cnt(fc0)
    );

    hazard_ctrl #(.REG_ADDR_W(5), .MDU_TIMEOUT(4), .CNT_W(3)) u1 (
        .clk(clk), .rst(rst),
        .id_rs_addr(rs_a), .id_rt_addr(rt_a), .id_rs_used(rs_u), .id_rt_used(rt_u),
        .id_is_mdu(is_mdu), .ex_is_load(is_ld), .ex_wr_addr(wr_a),
        .ex_branch_taken(br), .mdu_done(done),
        .pc_hold(ph1), .if_id_hold(ih1), .if_id_flush(ff1), .id_ex_stall(st1),
        .id_ex_flush(ef1), .mdu_start(ms1), .mdu_err(err1),
        .stall_cnt(sc1), .flush_cnt(fc1)
    );

    assign ctl0 = {ph0, ih0, ff0, st0, ef0, ms0};
    assign ctl1 = {ph1, ih1, ff1, st1, ef1, ms1};

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic hazard();
        return is_ld && (wr_a != 5'd0) &&
               ((rs_u && rs_a == wr_a) || (rt_u && rt_a == wr_a));
    endfunction

    function automatic logic [5:0] expect_out(input int i);
        if (rst) return 6'b0;
        case (m_mode[i])
            0: begin
                if (br)          return FLSH;
                if (hazard())    return HOLD;
                if (is_mdu)      return START;
                return 6'b0;
            end
            1:       return HOLD;
            default: return 6'b0;
        endcase
    endfunction

    task automatic model_update();
        logic [5:0] e;
        for (int i = 0; i < 2; i++) begin
            e = expect_out(i);
            if (rst) begin
                m_mode[i] = 0; m_el[i] = 0; m_err[i] = 0; m_st[i] = 0; m_fl[i] = 0;
            end else begin
                if (e[5] && m_st[i] < cmax[i]) m_st[i]++;
                if (e[3] && m_fl[i] < cmax[i]) m_fl[i]++;
                case (m_mode[i])
                    0: if (e[0]) begin m_mode[i] = 1; m_el[i] = 1; end
                    1: begin
                        if (done) m_mode[i] = 2;
                        else if (m_el[i] == tmo[i]) begin m_err[i] = 1; m_mode[i] = 2; end
                        else m_el[i]++;
                    end
                    default: m_mode[i] = 0;
                endcase
            end
        end
    endtask

    // Compare everything against the model, advance one clock, land on negedge.
    task automatic tick();
        #1;
        chk("ctl0",   ctl0, expect_out(0));
        chk("err0",   err0, m_err[0]);
        chk("stall0", sc0,  m_st[0]);
        chk("flush0", fc0,  m_fl[0]);
        chk("ctl1",   ctl1, expect_out(1));
        chk("err1",   err1, m_err[1]);
        chk("stall1", sc1,  m_st[1]);
        chk("flush1", fc1,  m_fl[1]);
        last0 = ctl0;
        last1 = ctl1;
        model_update();
        @(negedge clk);
    endtask

    task automatic quiet();
        rst = 0; rs_a = 0; rt_a = 0; wr_a = 0; rs_u = 0; rt_u = 0;
        is_mdu = 0; is_ld = 0; br = 0; done = 0;
    endtask

    task automatic do_reset();
        quiet();
        rst = 1; is_mdu = 1; br = 1;   // active inputs must be masked
        tick();
        quiet();
    endtask

    typedef struct {
        logic [4:0] rs, rt, wr;
        logic       rsu, rtu, ld, b;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int holds, starts;
        cmax[0] = 64'hFFFF_FFFF; cmax[1] = 7;
        tmo[0]  = 64;            tmo[1]  = 4;
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0; m_el[i] = 0; m_err[i] = 0; m_st[i] = 0; m_fl[i] = 0;
        end

        //          rs     rt     wr    rsu  rtu  ld   b    exp
        tbl[0] = '{5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0, 6'b0};
        tbl[1] = '{5'd8, 5'd0, 5'd8, 1'b1,1'b0,1'b1,1'b0, HOLD};
        tbl[2] = '{5'd0, 5'd0, 5'd0, 1'b1,1'b0,1'b1,1'b0, 6'b0};
        tbl[3] = '{5'd3, 5'd5, 5'd5, 1'b1,1'b1,1'b1,1'b0, HOLD};
        tbl[4] = '{5'd8, 5'd0, 5'd8, 1'b0,1'b0,1'b1,1'b0, 6'b0};
        tbl[5] = '{5'd8, 5'd0, 5'd8, 1'b1,1'b0,1'b0,1'b0, 6'b0};
        tbl[6] = '{5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b1, FLSH};
        tbl[7] = '{5'd8, 5'd0, 5'd8, 1'b1,1'b0,1'b1,1'b1, FLSH};
        tbl[8] = '{5'd7, 5'd9, 5'd8, 1'b1,1'b1,1'b1,1'b0, 6'b0};
        tbl[9] = '{5'd2, 5'd8, 5'd8, 1'b1,1'b0,1'b1,1'b0, 6'b0};

        quiet();
        @(negedge clk);
        do_reset();
        #1;
        chk("rst_stall", sc0, 0);
        chk("rst_flush", fc0, 0);
        chk("rst_err",   err0, 0);
        chk("rst_ctl",   ctl0, 0);

        // Single-cycle IDLE decode vectors.
        for (int i = 0; i < 10; i++) begin
            rs_a = tbl[i].rs; rt_a = tbl[i].rt; wr_a = tbl[i].wr;
            rs_u = tbl[i].rsu; rt_u = tbl[i].rtu; is_ld = tbl[i].ld; br = tbl[i].b;
            tick();
            chk($sformatf("vec%0d", i), last0, tbl[i].exp);
        end

        // Load-use: exactly one bubble.
        do_reset();
        rs_a = 8; wr_a = 8; rs_u = 1; is_ld = 1;
        tick();
        chk("lu_hold", last0, HOLD);
        quiet();
        tick();
        chk("lu_after", last0, 0);
        chk("lu_stall", sc0, 1);

        // MDU with mdu_done five cycles after start.
        do_reset();
        holds = 0; starts = 0;
        is_mdu = 1;
        tick();
        holds += last0[5]; starts += last0[0];
        is_mdu = 0;
        for (int c = 1; c <= 5; c++) begin
            done = (c == 5);
            tick();
            holds += last0[5]; starts += last0[0];
        end
        done = 0;
        tick();
        chk("mdu_release", last0, 0);
        is_mdu = 0;
        tick();
        chk("mdu_holds",  holds, 6);
        chk("mdu_starts", starts, 1);
        chk("mdu_stall",  sc0, 6);

        // Branch priority over load-use and MDU.
        do_reset();
        rs_a = 8; wr_a = 8; rs_u = 1; is_ld = 1; is_mdu = 1; br = 1;
        tick();
        chk("br_prio", last0, FLSH);
        quiet();
        tick();
        chk("br_idle",  last0, 0);
        chk("br_flush", fc0, 1);
        chk("br_stall", sc0, 0);

        // Timeout and saturation on u1; u0 is left waiting for the reset test.
        do_reset();
        holds = 0;
        is_mdu = 1;
        for (int c = 0; c < 6; c++) begin
            tick();
            holds += last1[5];
        end
        chk("to_holds",   holds, 5);
        chk("to_release", last1, 0);
        chk("to_err",     err1, 1);
        for (int c = 0; c < 6; c++) tick();
        chk("sat_stall", sc1, 7);
        chk("err_sticky", err1, 1);

        // Reset while u0 is in MDU_WAIT.
        is_mdu = 0;
        tick();
        chk("pre_rst_hold", last0, HOLD);
        rst = 1;
        tick();
        chk("rst_mid_ctl", last0, 0);
        rst = 0;
        #1;
        chk("rst_mid_stall", sc0, 0);
        chk("rst_mid_err1",  err1, 0);
        tick();
        chk("rst_mid_idle", last0, 0);

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            rst    = ($urandom_range(0, 99) == 0);
            rs_a   = 5'($urandom_range(0, 3));
            rt_a   = 5'($urandom_range(0, 3));
            wr_a   = 5'($urandom_range(0, 3));
            rs_u   = 1'($urandom_range(0, 1));
            rt_u   = 1'($urandom_range(0, 1));
            is_ld  = 1'($urandom_range(0, 1));
            is_mdu = ($urandom_range(0, 4) == 0);
            br     = ($urandom_range(0, 5) == 0);
            done   = ($urandom_range(0, 5) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller that drives the hold, bubble and flush controls of the IF/ID and ID/EX pipeline registers and the PC. It detects load-use hazards and taken branches resolved in EX. It also sequences the multi-cycle multiply/divide unit (MDU): the MDU instruction is held in ID while the unit runs. It keeps saturating stall/flush performance counters and a sticky MDU-timeout error flag.

## Interface
- REG_ADDR_W, 5, register address width
- MDU_TIMEOUT, 64, max MDU_WAIT cycles before abort (≥2)
- CNT_W, 32, performance counter width
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- id_rs_addr, id_rt_addr  in  REG_ADDR_W  source register addresses of the ID instruction
- id_rs_used, id_rt_used  in  1  the ID instruction reads rs / rt
- id_is_mdu  in  1  the ID instruction needs the MDU
- ex_is_load  in  1  the EX instruction is a load
- ex_wr_addr  in  REG_ADDR_W  destination register of the EX instruction
- ex_branch_taken  in  1  a branch/jump resolved taken in EX
- mdu_done  in  1  MDU result ready (pulse)
- pc_hold  out  1  PC keeps its value
- if_id_hold  out  1  IF/ID keeps its value
- if_id_flush  out  1  IF/ID is cleared
- id_ex_stall  out  1  ID/EX loads a bubble (all zeros)
- id_ex_flush  out  1  ID/EX is cleared
- mdu_start  out  1  single-cycle MDU launch pulse
- mdu_err  out  1  sticky; set on MDU timeout
- stall_cnt  out  CNT_W  cycles with pc_hold=1, saturating
- flush_cnt  out  CNT_W  cycles with if_id_flush=1, saturating

## Operation
- States: IDLE, MDU_WAIT, MDU_RELEASE. The state register and counters are registered; the control outputs are combinational from state and inputs (Mealy), so the pipeline registers act in the same cycle.
- load_use = ex_is_load & ex_wr_addr≠0 & ((id_rs_used & id_rs_addr==ex_wr_addr) | (id_rt_used & id_rt_addr==ex_wr_addr)).
- IDLE, evaluated in priority order:
  - ex_branch_taken: assert if_id_flush and id_ex_flush. No holds, no mdu_start. A wrong-path MDU instruction is never launched.
  - else load_use: assert pc_hold, if_id_hold and id_ex_stall for this cycle only. Stay in IDLE. An MDU instruction is launched on a later cycle once the hazard clears.
  - else id_is_mdu: assert mdu_start, pc_hold, if_id_hold and id_ex_stall. Next state MDU_WAIT. Clear wait_cnt to 1.
  - else: all outputs 0.
- MDU_WAIT:
  - pc_hold, if_id_hold and id_ex_stall are asserted every cycle.
  - ex_branch_taken is ignored, because EX holds only bubbles.
  - mdu_done=1: next state MDU_RELEASE.
  - else if wait_cnt==MDU_TIMEOUT: set mdu_err; next state MDU_RELEASE.
  - else wait_cnt+1.
- MDU_RELEASE: all controls 0 and mdu_start suppressed. The MDU instruction advances to EX. Next state IDLE unconditionally.
- mdu_done is sampled only in MDU_WAIT and ignored elsewhere.
- Counters: stall_cnt +1 per cycle with pc_hold=1; flush_cnt +1 per cycle with if_id_flush=1. Both hold at 2^CNT_W−1.
- mdu_err is cleared only by rst.

## Timing
- Reset: while rst=1, all control outputs are forced 0. The next-cycle state is IDLE, wait_cnt=0, stall_cnt=0, flush_cnt=0, mdu_err=0.
- Reset mid-MDU: the state returns to IDLE with no release cycle. The MDU is reset externally by the same rst.
- Load-use costs exactly 1 bubble.
- MDU launch: let start be cycle T, with mdu_done arriving in MDU_WAIT cycle T+k (k≥1).
  - The front end is held for 1+k cycles.
  - Release happens at T+k+1.
  - A new mdu_start is possible no earlier than T+k+2.
- Timeout: with no mdu_done, the last hold cycle is T+MDU_TIMEOUT, and the release is at T+MDU_TIMEOUT+1.
- Branch flush has zero added latency; the flush is asserted in the same cycle as ex_branch_taken.

## Structure
- hazard_pkg: state enum (IDLE, MDU_WAIT, MDU_RELEASE); REG_ZERO constant; width helper for wait_cnt ($clog2(MDU_TIMEOUT+1)).
- Sub-module sat_counter (parameter W; inputs clk, rst, inc; output cnt), instantiated twice, for stall_cnt and flush_cnt.

## Test plan
- Load-use: ex_is_load=1, ex_wr_addr=8, id_rs_addr=8, id_rs_used=1 → exactly one cycle with pc_hold=if_id_hold=id_ex_stall=1; stall_cnt=1. The same case with ex_wr_addr=0 → no stall.
- MDU: id_is_mdu=1 in IDLE, mdu_done pulsed 5 cycles after start → mdu_start asserted once, 6 hold cycles, one release cycle with all controls 0, then IDLE; stall_cnt=6.
- Branch priority: ex_branch_taken=1 together with load_use and id_is_mdu → if_id_flush=id_ex_flush=1, no hold, no mdu_start; flush_cnt=1.
- Timeout: MDU_TIMEOUT=4, mdu_done never asserted → 5 hold cycles, mdu_err=1, release, then IDLE; mdu_err stays 1 until rst.
- Reset mid-MDU: rst=1 during MDU_WAIT → controls 0 while rst is high; afterwards state IDLE, counters 0, mdu_err 0.
- Saturation: CNT_W=3 with 10 consecutive hold cycles → stall_cnt stops at 7.
